// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO initiator: peripheral address map, FSM encoding
// and default timeout settings used when MMIO_TIMEOUT_EN is defined.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE          = 32'h8000_0000;
    localparam logic [31:0] MMIO_UART_TXDATA   = 32'h8000_0000;
    localparam logic [31:0] MMIO_UART_STATUS   = 32'h8000_0004;
    localparam logic [31:0] MMIO_UART_RXDATA   = 32'h8000_0008;
    localparam logic [31:0] MMIO_LEDS          = 32'h8000_000C;
    localparam logic [31:0] MMIO_SWITCHES      = 32'h8000_0010;
    localparam logic [31:0] MMIO_TIMER         = 32'h8000_0014;
    localparam logic [31:0] MMIO_BUTTONS       = 32'h8000_0018;

    localparam int unsigned MMIO_TIMEOUT_DEFAULT       = 65536;
    localparam logic [31:0] MMIO_TIMEOUT_RDATA_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mmio_state_e;

    // Peripheral registers are word-sized; byte offsets within a word are dropped.
    function automatic logic [31:0] mmio_word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mmio_timeout_counter.sv
// Transaction watchdog counter: cleared at request acceptance, counts enabled
// cycles and raises a registered terminal-count flag one cycle after reaching TERMINAL-1.
module mmio_timeout_counter #(
    parameter int unsigned TERMINAL = 65536
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int W = $clog2(TERMINAL);
    localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

    logic [W-1:0] r_count;
    logic         r_tc;

    // The count saturates at LAST so a lingering enable cannot wrap it back to zero.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (i_enable) begin
            r_tc <= (r_count == LAST);
            if (r_count != LAST) begin
                r_count <= r_count + 1'b1;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign o_tc = r_tc;

endmodule

// File: rtl/mmio_initiator.sv
// MMIO bus initiator: turns a CPU load/store into a held mmio_* request and returns
// a one-cycle cpu_ready pulse. Define MMIO_TIMEOUT_EN to build the timeout watchdog.
module mmio_initiator
    import mmio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MMIO_TIMEOUT_DEFAULT,
    parameter logic [31:0] TIMEOUT_RDATA  = MMIO_TIMEOUT_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mmio_valid,
    output logic        mmio_write,
    output logic [31:0] mmio_addr,
    output logic [31:0] mmio_wdata,
    output logic [3:0]  mmio_wstrb,
    input  logic [31:0] mmio_rdata,
    input  logic        mmio_ready,
    output logic        busy,
    output logic        err_timeout,
    input  logic        err_clear
);

    mmio_state_e r_state;
    mmio_state_e w_next_state;

    logic        w_accept;
    logic        w_ack;
    logic        w_abort;
    logic        w_tc;

    logic        r_mmio_valid;
    logic        r_mmio_write;
    logic [31:0] r_mmio_addr;
    logic [31:0] r_mmio_wdata;
    logic [3:0]  r_mmio_wstrb;
    logic [31:0] r_cpu_rdata;
    logic        r_cpu_ready;
    logic        r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ready wins over a coincident terminal count; stray readies outside REQ fall through.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_ack        = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_valid && !r_cpu_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mmio_ready) begin
                    w_ack        = 1'b1;
                    w_next_state = ST_DONE;
                end else if (w_tc) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mmio_valid <= 1'b0;
            r_mmio_write <= 1'b0;
            r_mmio_addr  <= '0;
            r_mmio_wdata <= '0;
            r_mmio_wstrb <= '0;
            r_cpu_rdata  <= '0;
            r_cpu_ready  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_busy      <= (w_next_state != ST_IDLE);
            r_cpu_ready <= w_ack | w_abort;
            if (w_accept) begin
                r_mmio_valid <= 1'b1;
                r_mmio_write <= |cpu_wstrb;
                r_mmio_addr  <= mmio_word_addr(cpu_addr);
                r_mmio_wdata <= cpu_wdata;
                r_mmio_wstrb <= cpu_wstrb;
            end
            if (w_ack) begin
                r_mmio_valid <= 1'b0;
                r_cpu_rdata  <= r_mmio_write ? '0 : mmio_rdata;
            end else if (w_abort) begin
                r_mmio_valid <= 1'b0;
                r_cpu_rdata  <= r_mmio_write ? '0 : TIMEOUT_RDATA;
            end
        end
    end

`ifdef MMIO_TIMEOUT_EN
    logic w_count_en;
    logic r_err_timeout;

    assign w_count_en = (r_state == ST_REQ) && !mmio_ready;

    mmio_timeout_counter #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_accept),
        .i_enable (w_count_en),
        .o_tc     (w_tc)
    );

    // A timeout in the same cycle as err_clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_timeout <= 1'b0;
        end else if (w_abort) begin
            r_err_timeout <= 1'b1;
        end else if (err_clear) begin
            r_err_timeout <= 1'b0;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    logic w_unused_cfg;

    assign w_tc         = 1'b0;
    assign err_timeout  = 1'b0;
    assign w_unused_cfg = err_clear | (TIMEOUT_CYCLES == 0);
`endif

    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_ready  = r_cpu_ready;
    assign mmio_valid = r_mmio_valid;
    assign mmio_write = r_mmio_write;
    assign mmio_addr  = r_mmio_addr;
    assign mmio_wdata = r_mmio_wdata;
    assign mmio_wstrb = r_mmio_wstrb;
    assign busy       = r_busy;

endmodule

// File: doc/mmio_initiator.md
# mmio_initiator

Initiator side of the MMIO peripheral bus. Accepts single CPU load/store requests already decoded to the 0x8000_0000 peripheral region by the memory controller, drives the `mmio_*` request onto the peripheral block, and holds it stable until `mmio_ready`. It then returns one `cpu_ready` pulse with read data. Optionally bounds each transaction with a timeout watchdog so a hung or unmapped responder cannot stall the CPU forever.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 65536: max cycles in REQ before abort (only with `MMIO_TIMEOUT_EN`); legal range 2..2^24
- `TIMEOUT_RDATA`, default 32'hFFFF_FFFF: `cpu_rdata` returned on a timed-out read

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `cpu_valid`  in  1  CPU request; held until `cpu_ready`
- `cpu_addr`  in  32  byte address
- `cpu_wdata`  in  32  store data
- `cpu_wstrb`  in  4  byte strobes; 0 = read, nonzero = write
- `cpu_rdata`  out  32  load data; valid while `cpu_ready`=1
- `cpu_ready`  out  1  one-cycle completion pulse
- `mmio_valid`  out  1  request to peripheral block
- `mmio_write`  out  1  1 = write
- `mmio_addr`  out  32  word-aligned address
- `mmio_wdata`  out  32  write data
- `mmio_wstrb`  out  4  byte strobes
- `mmio_rdata`  in  32  response data
- `mmio_ready`  in  1  one-cycle response pulse from the peripheral block
- `busy`  out  1  high in any state except IDLE
- `err_timeout`  out  1  sticky timeout flag
- `err_clear`  in  1  clears `err_timeout`

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: on `cpu_valid`=1 and `cpu_ready`=0, latch the request and go to REQ.
  - `mmio_write` = |`cpu_wstrb`.
  - `mmio_addr` = {`cpu_addr`[31:2], 2'b00}.
  - `mmio_wdata` and `mmio_wstrb` pass through unchanged.
  - Clear the timeout counter.
- REQ: `mmio_valid`=1. All `mmio_*` request outputs are held constant.
  - On `mmio_ready`=1: capture `cpu_rdata` = `mmio_write` ? 0 : `mmio_rdata`, drop `mmio_valid`, pulse `cpu_ready`, go to DONE.
  - Otherwise the counter increments by 1 each cycle.
  - Timeout (macro on): when the counter reaches `TIMEOUT_CYCLES`-1 with `mmio_ready`=0, drop `mmio_valid`, return `TIMEOUT_RDATA` (reads) or 0 (writes), pulse `cpu_ready`, set `err_timeout`, go to DONE.
- DONE: `cpu_ready`=1 for exactly this cycle; return to IDLE next cycle. A new request is not accepted in DONE.
- `mmio_ready` seen outside REQ is a stray and is ignored; it causes no state change.
- Boundary cases:
  - `mmio_ready` and timeout in the same cycle: ready wins; no error.
  - `err_clear` and a timeout event in the same cycle: set wins.
  - Busy responder (e.g. UART TX busy): the request simply stays in REQ; no retry logic is needed here.
- Reset, including mid-transaction: state to IDLE, request dropped immediately, no `cpu_ready` issued.
  - Output reset values: `mmio_valid`, `mmio_write`, `cpu_ready`, `busy`, `err_timeout` = 0; `mmio_addr`, `mmio_wdata`, `cpu_rdata` = 0; `mmio_wstrb` = 0; counter = 0.

## Timing
- All outputs are registered.
- Minimum latency, with a responder that acks one cycle after valid:
  - cycle 0: `cpu_valid` sampled
  - cycle 1: `mmio_valid`=1
  - cycle 2: `mmio_ready`=1
  - cycle 3: `cpu_ready`=1 and `mmio_valid`=0
- `mmio_valid` is guaranteed low in the cycle after `mmio_ready` is sampled. This means a responder gated on `valid && !ready` never sees a second request.
- Back-to-back throughput is 4 cycles per access at minimum (the DONE cycle plus a new IDLE sample).
- Timeout abort: `cpu_ready` is high exactly `TIMEOUT_CYCLES`+1 cycles after the first REQ cycle.

## Configuration
- `MMIO_TIMEOUT_EN` defined: timeout counter, abort path and `err_timeout` are present, as described above.
- `MMIO_TIMEOUT_EN` undefined: no counter is built; REQ waits indefinitely; `err_timeout` is tied to 0; `err_clear` and both parameters are ignored.

## Structure
- Package `mmio_pkg`:
  - peripheral address map constants: 0x8000_0000 TX data through 0x8000_0018 buttons
  - FSM state encoding
  - `MMIO_TIMEOUT_DEFAULT` = 65536
  - `MMIO_TIMEOUT_RDATA_DEFAULT`
- Sub-module `mmio_timeout_counter` (clear, enable, terminal-count pulse; width = $clog2(`TIMEOUT_CYCLES`)). It is instantiated only under `MMIO_TIMEOUT_EN`.

## Test plan
- Read of 0x8000_0018, responder acks in 1 cycle with 0x0000_0003 → `cpu_ready` at cycle 3, `cpu_rdata`=0x3, `mmio_write`=0.
- Write 0x41 with `cpu_wstrb`=4'b0001 to 0x8000_0000, responder stalls 10 cycles (TX busy) → `mmio_valid` held with stable addr/data for 10 cycles, then `cpu_ready`=1, `cpu_rdata`=0.
- Unaligned read at 0x8000_0013 → `mmio_addr`=0x8000_0010.
- `TIMEOUT_CYCLES`=16, no ack → `cpu_ready` after 17 REQ-referenced cycles, `cpu_rdata`=0xFFFF_FFFF, `err_timeout`=1 until `err_clear`; with the macro off, no completion after 1000 cycles.
- `mmio_ready` coincident with terminal count → normal completion, `err_timeout`=0.
- `reset` asserted in REQ → `mmio_valid`=0 next cycle, no `cpu_ready`; a stray `mmio_ready` in IDLE causes no response.
